sr_cmd_gen: RTL and testbench
=============================

SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameters SHALL be, one per line:
  PULSE_W, 2, cycles out_s/out_r is held high per command (>=1)
  GAP_W, 1, idle cycles with both drive lines low after each pulse (>=0)
  DEPTH, 4, command queue entries (power of two, >=2)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock, all state on rising edge
  n_rst  input  1  asynchronous, active-low reset
  req_valid  input  1  command offered
  req_level  input  1  requested latch level (1 = set, 0 = reset)
  req_ready  output  1  queue can accept a command
  out_s  output  1  set drive to SR latch
  out_r  output  1  reset drive to SR latch
  shadow_q  output  1  level the latch holds after the last completed pulse
  busy  output  1  queue non-empty or FSM not IDLE

Function
REQ-003 A command SHALL be accepted on a rising edge where req_valid && req_ready; req_ready SHALL equal !full, registered.
REQ-004 Accepted commands SHALL be issued strictly in arrival order; none dropped except per REQ-016.
REQ-005 FSM states SHALL be IDLE, PULSE, GAP.
REQ-006 IDLE: queue non-empty -> pop head, load counter, go PULSE; else stay IDLE.
REQ-007 PULSE: out_s = level, out_r = !level for exactly PULSE_W cycles; then GAP (GAP_W>0) or IDLE (GAP_W=0).
REQ-008 GAP: out_s = out_r = 0 for exactly GAP_W cycles, then IDLE.
REQ-009 out_s and out_r SHALL never be high in the same cycle, and SHALL be low in IDLE and GAP; both registered outputs.
REQ-010 shadow_q SHALL take the command level on the edge ending the last PULSE cycle.
REQ-011 Latency: command accepted on edge N SHALL drive its line from cycle N+2 (queue empty, FSM IDLE); command period = 1 + PULSE_W + GAP_W cycles.
REQ-012 Push and pop on the same edge SHALL both take effect; push to a full queue is impossible (req_ready low); pop of an empty queue SHALL not occur.
REQ-013 Counter width SHALL be $clog2(max(PULSE_W,GAP_W)+1); occupancy counter SHALL be $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-014 busy SHALL equal (state != IDLE) || !empty.

Reset
REQ-015 n_rst low SHALL asynchronously force: state IDLE, queue empty, counters 0, out_s=0, out_r=0, shadow_q=0, req_ready=1 after release, busy=0; a pulse in progress SHALL abort immediately with no resumption.

Configuration
REQ-016 With SR_CMD_SKIP_EN defined: an IDLE pop whose level equals shadow_q SHALL be discarded (no PULSE, no GAP, FSM stays IDLE, next pop next cycle); without it, every command SHALL produce a full pulse.

Structure
REQ-017 Package sr_cmd_pkg SHALL hold the FSM state enum (2-bit) and a command typedef (1-bit level).
REQ-018 Queue SHALL be a sub-module sr_cmd_fifo (DEPTH, push/pop/full/empty/head); FSM and drive registers remain in sr_cmd_gen.

Verification (PULSE_W=2, GAP_W=1, DEPTH=4)
REQ-019 Reset: n_rst low 3 cycles -> out_s=out_r=shadow_q=busy=0, req_ready=1 in cycle after release.
REQ-020 Single set: req level=1 accepted edge 0 -> out_s high cycles 2-3, low cycle 4 (GAP), shadow_q=1 from cycle 4, busy low from cycle 5.
REQ-021 Back-to-back levels 1,0,1,0,1,0,1,0 with req_valid held -> req_ready drops when occupancy hits 4, all 8 commands issued in order, out_s/out_r alternate with 4-cycle period, no cycle with both high.
REQ-022 shadow_q=1, req level=1: SR_CMD_SKIP_EN defined -> no drive pulse, busy low within 2 cycles; undefined -> out_s high 2 cycles.
REQ-023 n_rst asserted mid-pulse while out_r high with 3 queued -> out_r 0 same cycle, shadow_q 0, queue empty, no pulse after release.

Source files
------------

// File: rtl/sr_cmd_pkg.sv
// Shared types for the SR latch command generator: FSM state encoding and queued command format.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic level;
  } cmd_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// Command queue for sr_cmd_gen: DEPTH entries, wrapping pointers, registered full flag.
module sr_cmd_fifo
  import sr_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic push,
  input  cmd_t push_cmd,
  input  logic pop,
  output logic full,
  output logic empty,
  output cmd_t head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  cmd_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count != '0);

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Full is registered from the next occupancy so req_ready has no input-to-output path.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count  <= count_next;
      full_q <= (count_next == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = full_q;

endmodule

// File: rtl/sr_cmd_gen.sv
// SR latch command generator: queues set/reset requests and replays them as timed, non-overlapping pulses.
// Optional build macro SR_CMD_SKIP_EN drops queued commands that would not change the latch level.
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int DEPTH   = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic out_s,
  output logic out_r,
  output logic shadow_q,
  output logic busy
);

  localparam int CW = $clog2(max2(PULSE_W, GAP_W) + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_W > 0) ? (GAP_W - 1) : 0);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          level_q;
  logic          level_next;
  logic          shadow_next;
  logic          out_s_next;
  logic          out_r_next;
  logic          pop;
  logic          push;
  logic          skip_head;
  logic          fifo_full;
  logic          fifo_empty;
  cmd_t          head;
  cmd_t          push_cmd;

  assign push           = req_valid && req_ready;
  assign push_cmd.level = req_level;
  assign req_ready      = !fifo_full;

  sr_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

`ifdef SR_CMD_SKIP_EN
  assign skip_head = (head.level == shadow_q);
`else
  assign skip_head = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    level_next  = level_q;
    shadow_next = shadow_q;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!skip_head) begin
            state_next = ST_PULSE;
            cnt_next   = PULSE_LOAD;
            level_next = head.level;
          end
        end
      end
      // The edge that ends the last pulse cycle is where the latch is known to hold the new level.
      ST_PULSE: begin
        if (cnt == '0) begin
          shadow_next = level_q;
          if (GAP_W > 0) begin
            state_next = ST_GAP;
            cnt_next   = GAP_LOAD;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    out_s_next = (state_next == ST_PULSE) && level_next;
    out_r_next = (state_next == ST_PULSE) && !level_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      level_q  <= 1'b0;
      shadow_q <= 1'b0;
      out_s    <= 1'b0;
      out_r    <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      level_q  <= level_next;
      shadow_q <= shadow_next;
      out_s    <= out_s_next;
      out_r    <= out_r_next;
    end
  end

  assign busy = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Scoreboard bench for sr_cmd_gen: accepted commands feed an expected-pulse queue checked by a monitor.
module tb_sr_cmd_gen;

  localparam int PULSE_W = 2;
  localparam int GAP_W   = 1;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic out_s;
  logic out_r;
  logic shadow_q;
  logic busy;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];
  bit prev_act = 1'b0;
  bit cur_level = 1'b0;
  int run_len = 0;
  bit ready_stalled = 1'b0;
`ifdef SR_CMD_SKIP_EN
  bit model_last = 1'b0;
`endif

  sr_cmd_gen #(
    .PULSE_W(PULSE_W),
    .GAP_W  (GAP_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .req_valid(req_valid),
    .req_level(req_level),
    .req_ready(req_ready),
    .out_s    (out_s),
    .out_r    (out_r),
    .shadow_q (shadow_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the edge that accepted the command.
  task automatic applyStimulus(input bit lvl);
    int n;
    req_valid = 1'b1;
    req_level = lvl;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (req_ready) break;
      ready_stalled = 1'b1;
    end
    if (n == 100) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    checkOutput("drain_queue", exp_q.size(), 0);
    checkOutput("idle_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the oldest outstanding expected level, width and shadow update.
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_act = 1'b0;
      run_len  = 0;
    end else begin
      if (out_s && out_r) checkOutput("both_high", 1, 0);
      if ((out_s || out_r) && !prev_act) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", 1, 0);
          cur_level = out_s;
        end else begin
          cur_level = exp_q.pop_front();
          checkOutput("pulse_level", out_s, cur_level);
        end
        run_len = 1;
      end else if (out_s || out_r) begin
        run_len++;
        checkOutput("pulse_hold", out_s, cur_level);
      end else if (prev_act) begin
        checkOutput("pulse_width", run_len, PULSE_W);
        checkOutput("shadow_after", shadow_q, cur_level);
      end
      prev_act = out_s || out_r;
      if (req_valid && req_ready) begin
`ifdef SR_CMD_SKIP_EN
        if (req_level != model_last) begin
          exp_q.push_back(req_level);
          model_last = req_level;
        end
`else
        exp_q.push_back(req_level);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit lvl;
    n_rst     = 1'b0;
    req_valid = 1'b0;
    req_level = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_s", out_s, 0);
    checkOutput("rst_out_r", out_r, 0);
    checkOutput("rst_shadow", shadow_q, 0);
    checkOutput("rst_busy", busy, 0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_ready", req_ready, 1);

    $display("[TB] single set command");
    applyStimulus(1'b1);
    req_valid = 1'b0;
    checkOutput("set_c1_out_s", out_s, 0);
    @(posedge clk); #1;
    checkOutput("set_c2_out_s", out_s, 1);
    checkOutput("set_c2_out_r", out_r, 0);
    @(posedge clk); #1;
    checkOutput("set_c3_out_s", out_s, 1);
    @(posedge clk); #1;
    checkOutput("set_c4_out_s", out_s, 0);
    checkOutput("set_c4_shadow", shadow_q, 1);
    checkOutput("set_c4_busy", busy, 1);
    @(posedge clk); #1;
    checkOutput("set_c5_busy", busy, 0);

    $display("[TB] back-to-back alternating levels");
    ready_stalled = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus((i % 2) == 0);
    req_valid = 1'b0;
    checkOutput("ready_drop", ready_stalled, 1);
    waitIdle();
    checkOutput("b2b_shadow", shadow_q, 0);

    $display("[TB] repeated level");
    applyStimulus(1'b1);
    req_valid = 1'b0;
    waitIdle();
    applyStimulus(1'b1);
    req_valid = 1'b0;
    @(posedge clk); #1;
`ifdef SR_CMD_SKIP_EN
    @(posedge clk); #1;
    checkOutput("skip_busy", busy, 0);
    checkOutput("skip_out_s", out_s, 0);
`else
    checkOutput("noskip_out_s", out_s, 1);
`endif
    waitIdle();

    $display("[TB] random commands");
    for (int i = 0; i < 60; i++) begin
      lvl = 1'($urandom_range(0, 1));
      applyStimulus(lvl);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    waitIdle();

    $display("[TB] reset during pulse");
    for (int i = 0; i < 5; i++) applyStimulus((i % 2) == 0);
    req_valid = 1'b0;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_r) break;
    end
    checkOutput("saw_out_r", out_r, 1);
    #1;
    n_rst = 1'b0;
    exp_q.delete();
`ifdef SR_CMD_SKIP_EN
    model_last = 1'b0;
`endif
    #1;
    checkOutput("abort_out_r", out_r, 0);
    checkOutput("abort_out_s", out_s, 0);
    checkOutput("abort_shadow", shadow_q, 0);
    checkOutput("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_ready", req_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("post_abort_busy", busy, 0);
    checkOutput("post_abort_out_r", out_r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
